// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type, RV32 opcodes and register-usage decode
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_DRAIN, ST_HALTED} state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  function automatic logic rs1_used(input logic [6:0] op);
    return op inside {OP_LOAD, OP_IMM, OP_STORE, OP_RTYPE, OP_BRANCH, OP_JALR};
  endfunction
  function automatic logic rs2_used(input logic [6:0] op);
    return op inside {OP_STORE, OP_RTYPE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + 1'b1;
  assign count = r_count;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage pipe
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_branch_taken,
  input  logic             mem_dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t r_state, w_next;
  logic [DW-1:0] r_drain, w_drain_next;
  logic w_luh, w_stall_inc, w_flush_inc;
  assign w_luh = ex_mem_read && ex_rd != 5'd0 &&
                 ((rs1_used(id_opcode) && id_rs1 == ex_rd) ||
                  (rs2_used(id_opcode) && id_rs2 == ex_rd));
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pipe_hold    = 1'b0;
    halted       = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_next       = r_state;
    w_drain_next = r_drain;
    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          pc_write     = 1'b0;
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_flush  = 1'b1;
          w_drain_next = '0;
          w_next       = ST_DRAIN;
        end else if (mem_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          w_flush_inc = 1'b1;
        end else if (mem_dmem_req && !dmem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_hold   = 1'b1;
          w_stall_inc = 1'b1;
          w_next      = ST_MEM_WAIT;
        end else if (w_luh) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_flush  = 1'b1;
          w_stall_inc = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_hold   = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          w_next = ST_RUN;
          if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_luh) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        w_drain_next = DW'(r_drain + 1'b1);
        if (r_drain == DW'(DRAIN_CYCLES - 1)) w_next = ST_HALTED;
      end
      ST_HALTED: begin
        halted     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
      end
      default: w_next = ST_RUN;
    endcase
    // reset overrides everything so the pipe is frozen with no pending flush
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pipe_hold   = 1'b1;
      halted      = 1'b0;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= w_drain_next;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_stall_inc), .clear(1'b0), .count(stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_flush_inc), .clear(1'b0), .count(flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors with a queue-based scoreboard
module tb_pipeline_hazard_controller;
  import pipe_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_read, mem_branch_taken, mem_dmem_req, dmem_ready, halt_req;
  logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, halted;
  logic [3:0] stall_count, flush_count;
  int total = 0;
  int bad = 0;
  logic [14:0] exp_q[$];
  string name_q[$];
  logic [14:0] got, e;
  string nm;
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] HOLD = 7'b0000010;
  localparam logic [6:0] LUH  = 7'b0001000;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] HREQ = 7'b0111100;
  localparam logic [6:0] DRN  = 7'b0011000;
  localparam logic [6:0] HLT  = 7'b0000011;
  pipeline_hazard_controller #(.CNT_W(4), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
    .mem_dmem_req(mem_dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, halted,
             stall_count, flush_count};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s got=%b exp=%b (pc,ifw,ifid,idex,exmem,hold,halted,stall,flush)", nm, got, e);
      end
    end
  task automatic clr();
    id_opcode = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; mem_branch_taken = 1'b0; mem_dmem_req = 1'b0;
    dmem_ready = 1'b0; halt_req = 1'b0;
  endtask
  task automatic set_luh();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_opcode = OP_RTYPE; id_rs1 = 5'd1; id_rs2 = 5'd5;
  endtask
  task automatic chk(input logic [6:0] o, input logic [3:0] s, input logic [3:0] f, input string n);
    exp_q.push_back({o, s, f});
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    reset_n = 1'b0;
    clr();
    @(posedge clk);
    #1;
    mem_branch_taken = 1'b1; halt_req = 1'b1;
    chk(HOLD, 4'd0, 4'd0, "reset");
    reset_n = 1'b1; clr();
    chk(NORM, 4'd0, 4'd0, "idle");
    set_luh();
    chk(LUH, 4'd0, 4'd0, "luh_rtype_rs2");
    clr();
    chk(NORM, 4'd1, 4'd0, "luh_count");
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_opcode = OP_RTYPE;
    chk(NORM, 4'd1, 4'd0, "no_luh_x0");
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_opcode = OP_IMM; id_rs1 = 5'd3; id_rs2 = 5'd5;
    chk(NORM, 4'd1, 4'd0, "no_luh_imm_rs2");
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_opcode = OP_STORE; id_rs1 = 5'd2; id_rs2 = 5'd7;
    chk(LUH, 4'd1, 4'd0, "luh_store_rs2");
    clr();
    chk(NORM, 4'd2, 4'd0, "luh_count2");
    set_luh(); mem_branch_taken = 1'b1;
    chk(BR, 4'd2, 4'd0, "branch_over_luh");
    clr();
    chk(NORM, 4'd2, 4'd1, "flush_count");
    mem_dmem_req = 1'b1; dmem_ready = 1'b0;
    chk(HOLD, 4'd2, 4'd1, "mem_wait1");
    chk(HOLD, 4'd3, 4'd1, "mem_wait2");
    chk(HOLD, 4'd4, 4'd1, "mem_wait3");
    dmem_ready = 1'b1;
    chk(NORM, 4'd5, 4'd1, "mem_release");
    clr();
    chk(NORM, 4'd5, 4'd1, "mem_back_run");
    halt_req = 1'b1;
    chk(HREQ, 4'd5, 4'd1, "halt_req");
    clr(); set_luh(); mem_branch_taken = 1'b1; mem_dmem_req = 1'b1;
    chk(DRN, 4'd5, 4'd1, "drain1");
    chk(DRN, 4'd5, 4'd1, "drain2");
    chk(HLT, 4'd5, 4'd1, "halted1");
    halt_req = 1'b1;
    chk(HLT, 4'd5, 4'd1, "halted2");
    reset_n = 1'b0;
    chk(HOLD, 4'd0, 4'd0, "async_reset_halted");
    reset_n = 1'b1; clr();
    chk(NORM, 4'd0, 4'd0, "after_reset");
    for (int i = 0; i < 17; i++) begin
      set_luh();
      chk(LUH, (i > 15) ? 4'd15 : 4'(i), 4'd0, "sat_luh");
    end
    clr();
    chk(NORM, 4'd15, 4'd0, "sat_hold");
    mem_dmem_req = 1'b1;
    chk(HOLD, 4'd15, 4'd0, "stall_before_reset");
    reset_n = 1'b0;
    chk(HOLD, 4'd0, 4'd0, "reset_mid_stall");
    reset_n = 1'b1; clr();
    chk(NORM, 4'd0, 4'd0, "run_after_stall_reset");
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards between ID and EX, redirects on taken branches resolved in MEM, and freezes the pipe while data memory is busy.
- Drains the pipe on a halt request.
- Drives write enables and flushes for the PC and the IF/ID, ID/EX and EX/MEM registers, and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of the stall_count and flush_count performance counters
DRAIN_CYCLES, 2, cycles spent in DRAIN before HALTED (enough for MEM to reach WB)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_opcode  in  7  opcode of the instruction in ID
id_rs1  in  5  rs1 field in ID
id_rs2  in  5  rs2 field in ID
ex_rd  in  5  destination register of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
mem_branch_taken  in  1  branch/jump in MEM is taken; PC target is valid
mem_dmem_req  in  1  instruction in MEM is accessing data memory
dmem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  ebreak/ecall reached MEM
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to NOP (bubble)
exmem_flush  out  1  EX/MEM clear to NOP
pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB (enables low)
halted  out  1  core halted
stall_count  out  CNT_W  cycles lost to load-use and memory wait, saturating
flush_count  out  CNT_W  taken-branch redirects, saturating

Behaviour:
- Clock and reset: clk is the single clock. reset_n is asynchronous and active-low.
- While reset_n=0:
  - state=RUN, both counters=0, halted=0.
  - pc_write=0, ifid_write=0, pipe_hold=1, all flushes=0.
- Register usage decode (combinational, from id_opcode):
  - rs1_used for opcodes 0000011, 0010011, 0100011, 0110011, 1100011, 1100111.
  - rs2_used for 0100011, 0110011, 1100011.
- Load-use hazard: luh = ex_mem_read & ex_rd!=0 & ((rs1_used & id_rs1==ex_rd) | (rs2_used & id_rs2==ex_rd)).
- Outputs are combinational from the current state and inputs. State and counters are registered. Zero added latency.
- Default outputs: pc_write=1, ifid_write=1, all flushes=0, pipe_hold=0.
- FSM states RUN, MEM_WAIT, DRAIN, HALTED. In RUN the first matching row wins:
  1. halt_req: pc_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1; drain counter cleared to 0; next state DRAIN.
  2. mem_branch_taken: pc_write=1 (loads target), ifid_flush=1, idex_flush=1, exmem_flush=1; flush_count+1; stay in RUN. Concurrent luh is ignored (the flush kills that ID instruction).
  3. mem_dmem_req & !dmem_ready: pc_write=0, ifid_write=0, pipe_hold=1; stall_count+1; next state MEM_WAIT.
  4. luh: pc_write=0, ifid_write=0, idex_flush=1; stall_count+1; stay in RUN. The stall lasts exactly 1 cycle, because the load then leaves EX.
- mem_branch_taken and mem_dmem_req together is illegal (same MEM instruction). Branch priority applies.
- MEM_WAIT:
  - While dmem_ready=0: same hold outputs as RUN row 3; stall_count+1 each cycle.
  - On dmem_ready=1: outputs evaluated as RUN rows 2 and 4 for that cycle; next state RUN.
- DRAIN:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1. MEM/WB keeps flowing (pipe_hold=0).
  - Drain counter increments each cycle; after DRAIN_CYCLES cycles in DRAIN, next state HALTED.
  - Branch, memory and luh inputs are ignored.
- HALTED: halted=1, pc_write=0, ifid_write=0, pipe_hold=1. Only reset exits this state.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-drain returns to RUN at once, with no pending flush.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state typedef (2-bit enum).
  - Opcode constants OP_LOAD, OP_IMM, OP_STORE, OP_RTYPE, OP_BRANCH, OP_JALR. These are also used by the immediate extractor and the main control decoder.
- Sub-module sat_counter (parameter W; ports inc, clear, count; asynchronous active-low reset), instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_opcode=0110011, id_rs2=5 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_count 0->1.
- Non-hazard: ex_rd=0 with id_rs1=0, or id_opcode=0010011 with a matching id_rs2 -> pc_write=1, no flush, counters unchanged.
- Taken branch: mem_branch_taken=1 together with luh=1 -> three flushes, pc_write=1, flush_count=1, stall_count unchanged.
- Memory wait: mem_dmem_req=1, dmem_ready low for 3 cycles then high -> pipe_hold=1 for 3 cycles, state returns to RUN, stall_count=3.
- Halt: halt_req=1 -> DRAIN for 2 cycles, then halted=1 stays high despite branch/memory inputs; reset_n low clears halted and the counters asynchronously (mid-cycle).
- Saturation: force stall_count to all-ones via CNT_W=4 and 17 load-use stalls -> value stays at 15.
